// File: rtl/flex_counter_ud_if.sv
// flex_counter_ud_if
//   Control and status bundle for flex_counter_ud.
//   master : the block that drives the counter controls and observes status.
//   slave  : the counter itself.
//   Controls : clear, load, load_val, count_enable, count_down, one_shot,
//              rollover_val
//   Status   : count_out, rollover_flag, wrap_pulse, done
interface flex_counter_ud_if #(
  parameter int unsigned NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    count_down;
  logic                    one_shot;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    wrap_pulse;
  logic                    done;

  modport master (
    output clear, load, load_val, count_enable, count_down, one_shot,
           rollover_val,
    input  count_out, rollover_flag, wrap_pulse, done
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_down, one_shot,
           rollover_val,
    output count_out, rollover_flag, wrap_pulse, done
  );
endinterface

// File: rtl/flex_counter_ud.sv
// flex_counter_ud
//   Parametrised up/down counter with programmable rollover value R,
//   parallel load, one-shot (stop at terminal) mode and registered status.
//   Terminal value T is R when counting up and 1 when counting down.
//   Up sequence from 0 with R=3   : 0,1,2,3,1,2,3,...
//   Down sequence from 0 with R=3 : 0,3,2,1,3,2,1,...
// Ports
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : flex_counter_ud_if slave modport
//           clear        - sync clear of count and status (highest priority)
//           load         - sync parallel load of load_val
//           count_enable - advance one step this cycle
//           count_down   - 0 = up, 1 = down
//           one_shot     - stop at terminal value instead of restarting
//           rollover_val - terminal/restart value R
//           count_out    - current count (registered)
//           rollover_flag- high while count_out equals T (registered)
//           wrap_pulse   - one-cycle pulse when count restarts from T
//           done         - sticky, set on reaching T in one-shot mode
module flex_counter_ud #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  flex_counter_ud_if.slave  bus
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_q;
  logic                    flag_q;
  logic                    wrap_q;
  logic                    done_q;

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;
  logic                    next_wrap;
  logic                    next_done;
  logic [NUM_CNT_BITS-1:0] term_val;
  logic                    illegal_cfg;

  // Terminal value follows the direction sampled this cycle, so a direction
  // change while holding re-evaluates the flag on the next edge.
  assign term_val    = bus.count_down ? CNT_ONE : bus.rollover_val;
  assign illegal_cfg = (bus.rollover_val == CNT_ZERO);

  always_comb begin
    next_count = count_q;
    next_wrap  = 1'b0;
    next_done  = done_q;

    if (bus.clear) begin
      next_count = '0;
      next_done  = 1'b0;
    end else if (bus.load) begin
      next_count = bus.load_val;
      // Loading the terminal value in one-shot mode counts as reaching it.
      next_done  = bus.one_shot && (bus.load_val == term_val);
    end else if (bus.count_enable && !illegal_cfg && !done_q) begin
      if (!bus.count_down) begin
        if (count_q == bus.rollover_val) begin
          if (!bus.one_shot) begin
            next_count = CNT_ONE;
            next_wrap  = 1'b1;
          end
        end else begin
          // Values above R run through the top of the range and wrap to 0.
          next_count = count_q + CNT_ONE;
        end
      end else begin
        if (count_q == CNT_ONE) begin
          if (!bus.one_shot) begin
            next_count = bus.rollover_val;
            next_wrap  = 1'b1;
          end
        end else if (count_q == CNT_ZERO) begin
          // Starting from the cleared state is not a restart.
          next_count = bus.rollover_val;
        end else begin
          next_count = count_q - CNT_ONE;
        end
      end
      // Holding at T in one-shot mode also lands here, which makes done
      // sticky-set whether T was reached by stepping or was already present.
      if (bus.one_shot && (next_count == term_val)) begin
        next_done = 1'b1;
      end
    end

    next_flag = (next_count == term_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= next_count;
      flag_q  <= next_flag;
      wrap_q  <= next_wrap;
      done_q  <= next_done;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = wrap_q;
  assign bus.done          = done_q;

  // A restart can only happen while not in the one-shot done state.
  a_wrap_not_done: assert property (
    @(posedge clk) disable iff (!n_rst) wrap_q |-> !done_q
  );

endmodule

// File: tb/tb_flex_counter_ud.sv
module tb_flex_counter_ud;

  localparam int unsigned W = 4;

  typedef struct {
    string        nm;
    bit           clr;
    bit           ld;
    logic [W-1:0] lv;
    bit           en;
    bit           dn;
    bit           os;
    logic [W-1:0] r;
    logic [W-1:0] exp_cnt;
    bit           exp_flag;
    bit           exp_wrap;
    bit           exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  flex_counter_ud_if #(.NUM_CNT_BITS(W)) cif ();

  flex_counter_ud #(.NUM_CNT_BITS(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (cif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int c, input int f,
                           input int w, input int d);
    check({nm, " count"}, int'(cif.count_out), c);
    check({nm, " flag"},  int'(cif.rollover_flag), f);
    check({nm, " wrap"},  int'(cif.wrap_pulse), w);
    check({nm, " done"},  int'(cif.done), d);
  endtask

  task automatic drive(input bit clr, input bit ld, input logic [W-1:0] lv,
                       input bit en, input bit dn, input bit os,
                       input logic [W-1:0] r);
    cif.clear        = clr;
    cif.load         = ld;
    cif.load_val     = lv;
    cif.count_enable = en;
    cif.count_down   = dn;
    cif.one_shot     = os;
    cif.rollover_val = r;
  endtask

  function automatic void add(input string nm, input bit clr, input bit ld,
                              input logic [W-1:0] lv, input bit en,
                              input bit dn, input bit os,
                              input logic [W-1:0] r, input logic [W-1:0] c,
                              input bit f, input bit w, input bit d);
    vec_t v;
    v.nm = nm; v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.dn = dn;
    v.os = os; v.r = r; v.exp_cnt = c; v.exp_flag = f; v.exp_wrap = w;
    v.exp_done = d;
    vecs.push_back(v);
  endfunction

  initial begin
    //   name        clr ld lv  en dn os r   cnt fl wr dn
    add("clr0",       1, 0, 0,  0, 0, 0, 3,  0, 0, 0, 0);
    // Up, R=3
    add("up1",        0, 0, 0,  1, 0, 0, 3,  1, 0, 0, 0);
    add("up2",        0, 0, 0,  1, 0, 0, 3,  2, 0, 0, 0);
    add("up3",        0, 0, 0,  1, 0, 0, 3,  3, 1, 0, 0);
    add("up4",        0, 0, 0,  1, 0, 0, 3,  1, 0, 1, 0);
    add("up5",        0, 0, 0,  1, 0, 0, 3,  2, 0, 0, 0);
    add("up6",        0, 0, 0,  1, 0, 0, 3,  3, 1, 0, 0);
    add("up7",        0, 0, 0,  1, 0, 0, 3,  1, 0, 1, 0);
    add("up8",        0, 0, 0,  1, 0, 0, 3,  2, 0, 0, 0);
    add("clr1",       1, 0, 0,  0, 0, 0, 3,  0, 0, 0, 0);
    // Down, R=4
    add("dn1",        0, 0, 0,  1, 1, 0, 4,  4, 0, 0, 0);
    add("dn2",        0, 0, 0,  1, 1, 0, 4,  3, 0, 0, 0);
    add("dn3",        0, 0, 0,  1, 1, 0, 4,  2, 0, 0, 0);
    add("dn4",        0, 0, 0,  1, 1, 0, 4,  1, 1, 0, 0);
    add("dn5",        0, 0, 0,  1, 1, 0, 4,  4, 0, 1, 0);
    add("dn6",        0, 0, 0,  1, 1, 0, 4,  3, 0, 0, 0);
    add("clr2",       1, 0, 0,  0, 1, 0, 4,  0, 0, 0, 0);
    // One-shot up, R=5
    add("os_ld3",     0, 1, 3,  0, 0, 1, 5,  3, 0, 0, 0);
    add("os1",        0, 0, 0,  1, 0, 1, 5,  4, 0, 0, 0);
    add("os2",        0, 0, 0,  1, 0, 1, 5,  5, 1, 0, 1);
    add("os3",        0, 0, 0,  1, 0, 1, 5,  5, 1, 0, 1);
    add("os4",        0, 0, 0,  1, 0, 1, 5,  5, 1, 0, 1);
    add("os5",        0, 0, 0,  1, 0, 1, 5,  5, 1, 0, 1);
    add("os6",        0, 0, 0,  1, 0, 1, 5,  5, 1, 0, 1);
    add("os_clr",     1, 0, 0,  0, 0, 1, 5,  0, 0, 0, 0);
    // Priority
    add("clr_ld_en",  1, 1, 9,  1, 0, 1, 5,  0, 0, 0, 0);
    add("ld_en",      0, 1, 9,  1, 0, 0, 5,  9, 0, 0, 0);
    // Above-R load wraps through max, R=2
    add("ld14",       0, 1, 14, 0, 0, 0, 2,  14, 0, 0, 0);
    add("hi1",        0, 0, 0,  1, 0, 0, 2,  15, 0, 0, 0);
    add("hi2",        0, 0, 0,  1, 0, 0, 2,  0, 0, 0, 0);
    add("hi3",        0, 0, 0,  1, 0, 0, 2,  1, 0, 0, 0);
    add("hi4",        0, 0, 0,  1, 0, 0, 2,  2, 1, 0, 0);
    add("hi5",        0, 0, 0,  1, 0, 0, 2,  1, 0, 1, 0);
    // Illegal R=0 holds
    add("r0_a",       0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0);
    add("r0_b",       0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0);
    // Direction change while holding re-evaluates the flag
    add("dir_dn",     0, 0, 0,  0, 1, 0, 3,  1, 1, 0, 0);
    add("dir_up",     0, 0, 0,  0, 0, 0, 3,  1, 0, 0, 0);
    // Load of T in one-shot mode sets done; done holds even after one_shot drops
    add("ld_t",       0, 1, 3,  0, 0, 1, 3,  3, 1, 0, 1);
    add("ld_t_en",    0, 0, 0,  1, 0, 1, 3,  3, 1, 0, 1);
    add("os_off",     0, 0, 0,  1, 0, 0, 3,  3, 1, 0, 1);
    add("ld0",        0, 1, 0,  0, 0, 0, 3,  0, 0, 0, 0);
    // One-shot down, R=3
    add("osd1",       0, 0, 0,  1, 1, 1, 3,  3, 0, 0, 0);
    add("osd2",       0, 0, 0,  1, 1, 1, 3,  2, 0, 0, 0);
    add("osd3",       0, 0, 0,  1, 1, 1, 3,  1, 1, 0, 1);
    add("osd4",       0, 0, 0,  1, 1, 1, 3,  1, 1, 0, 1);
    add("clr3",       1, 0, 0,  0, 1, 1, 3,  0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 3);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    n_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].dn,
            vecs[i].os, vecs[i].r);
      @(posedge clk);
      #1;
      check_all(vecs[i].nm, int'(vecs[i].exp_cnt), int'(vecs[i].exp_flag),
                int'(vecs[i].exp_wrap), int'(vecs[i].exp_done));
    end

    // Asynchronous reset mid-count with flag and done both high
    drive(0, 1, 5, 0, 0, 1, 5);
    @(posedge clk);
    #1;
    check_all("pre_rst", 5, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1, 5);
    #2;
    n_rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 3);
    @(posedge clk);
    #1;
    check_all("post_rst", 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
